sa_line_loader: RTL and testbench
=================================

SA_LINE_LOADER -- requirements
Module: sa_line_loader

Interface
REQ-001 Parameter DEPTH, default 18, is the number of suffix-array lines written per load.
REQ-002 Parameter WIDTHS, default 1920, is the line width in bits.
REQ-003 Parameter ADDR_WIDTH, default 5, is the line address width.
REQ-004 Parameter IN_WIDTH, default 32, is the input word width; WORDS_PER_LINE = WIDTHS/IN_WIDTH (60).
REQ-005 The ports SHALL be as follows; one clock; reset is asynchronous and active-low:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a load, single-cycle pulse.
- in_data  input  IN_WIDTH  streamed SA word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data.
- wData  output  WIDTHS  line to SA memory write port.
- wEn  output  1  memory write strobe.
- wAddr  output  ADDR_WIDTH  memory line address.
- busy  output  1  load in progress.
- done  output  1  all DEPTH lines written.
- checksum  output  32  present only with SA_LOADER_CHECKSUM_EN.

Function
REQ-006 FSM states SHALL be IDLE, FILL, WRITE, DONE.
REQ-007 IDLE: start -> FILL, word counter = 0, line address = 0; other inputs ignored.
REQ-008 FILL: in_ready = 1; a word is accepted when in_valid && in_ready at a rising edge.
REQ-009 Accepted word j (0-based within line) SHALL occupy wData bits [j*IN_WIDTH +: IN_WIDTH].
REQ-010 Acceptance of word WORDS_PER_LINE-1 SHALL move FILL -> WRITE at that edge.
REQ-011 WRITE lasts exactly one cycle: wEn = 1, wData = assembled line, wAddr = current line address, in_ready = 0.
REQ-012 From WRITE: if line address == DEPTH-1 -> DONE; else line address +1, word counter 0, -> FILL.
REQ-013 wEn, wData and wAddr SHALL be registered; the memory captures the line on the edge ending the WRITE cycle.
REQ-014 Continuous in_valid SHALL give one line per WORDS_PER_LINE+1 cycles (61).
REQ-015 DONE: done = 1 held; in_ready = 0; start -> FILL with line address 0 (reload).
REQ-016 start in FILL or WRITE SHALL be ignored.
REQ-017 busy = 1 in FILL and WRITE, else 0.
REQ-018 wEn SHALL never be high outside WRITE; a partial line SHALL never be written.
REQ-019 wData SHALL hold its last value when wEn = 0.

Reset
REQ-020 rst_n low SHALL force IDLE, counters 0, wEn 0, wData 0, wAddr 0, in_ready 0, busy 0, done 0, checksum 0, immediately and regardless of clock.
REQ-021 Reset during FILL or WRITE SHALL discard the partial line with no write; the next start reloads from line 0.

Configuration
REQ-022 With macro SA_LOADER_CHECKSUM_EN defined, checksum SHALL be the 32-bit wrap-around sum of all accepted words since the last start, cleared on start.
REQ-023 Without SA_LOADER_CHECKSUM_EN, the checksum port and adder SHALL be absent; all other behaviour is identical.

Structure
REQ-024 Package sa_pkg SHALL hold DEPTH, WIDTHS, ADDR_WIDTH, IN_WIDTH, WORDS_PER_LINE defaults and the FSM state enum.
REQ-025 One sub-module, sa_line_packer (word counter plus line assembly register, with last-word flag), SHALL be instantiated; the FSM stays in sa_line_loader.
REQ-026 Elaboration SHALL fail if WIDTHS % IN_WIDTH != 0 or DEPTH > 2**ADDR_WIDTH.

Verification
REQ-027 Reset: rst_n low mid-cycle -> all outputs 0 asynchronously, state IDLE.
REQ-028 Start, words 0..1079 with in_valid held high -> 18 wEn pulses, 61 cycles apart, wAddr 0..17; line k word j = 60k+j; done = 1 after line 17.
REQ-029 Same stream with in_valid randomly high 50% -> identical memory contents, no lost or duplicated words.
REQ-030 rst_n low after word 30 of line 3 -> no wEn for line 3; restart and stream -> first write at wAddr 0.
REQ-031 start pulsed in FILL -> ignored, counters unchanged; start in DONE -> done = 0, busy = 1, next write at wAddr 0.
REQ-032 SA_LOADER_CHECKSUM_EN defined, 1080 words of value 1 -> checksum = 1080 at done; words 0xFFFFFFFF -> checksum = 0xFFFFFBC8.

Source files
------------

// File: rtl/sa_pkg.sv
// sa_pkg: shared defaults and FSM encoding for the suffix-array line loader.
package sa_pkg;
  localparam int SA_DEPTH          = 18;
  localparam int SA_WIDTHS         = 1920;
  localparam int SA_ADDR_WIDTH     = 5;
  localparam int SA_IN_WIDTH       = 32;
  localparam int SA_WORDS_PER_LINE = SA_WIDTHS / SA_IN_WIDTH;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} sa_state_e;
endpackage

// File: rtl/sa_line_packer.sv
// sa_line_packer: word counter and line assembly register.
// line_nxt_o already includes the word accepted this cycle, so the loader can register a full line on the last-word edge.
module sa_line_packer import sa_pkg::*; #(
  parameter int IN_WIDTH = SA_IN_WIDTH,
  parameter int WORDS    = SA_WORDS_PER_LINE,
  localparam int LW      = IN_WIDTH * WORDS,
  localparam int CW      = WORDS > 1 ? $clog2(WORDS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                acc_i,
  input  logic [IN_WIDTH-1:0] word_i,
  output logic                last_o,
  output logic [LW-1:0]       line_nxt_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] line_q;
  assign last_o = cnt_q == CW'(WORDS - 1);
  assign cnt_d  = clr_i ? '0 : !acc_i ? cnt_q : last_o ? '0 : cnt_q + 1'b1;
  always_comb begin
    line_nxt_o = line_q;
    if (acc_i) line_nxt_o[cnt_q*IN_WIDTH +: IN_WIDTH] = word_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_nxt_o;
    end
  end
endmodule

// File: rtl/sa_line_loader.sv
// sa_line_loader: streams IN_WIDTH words into WIDTHS-bit lines and writes DEPTH lines to SA memory.
// Optional running checksum of accepted words when SA_LOADER_CHECKSUM_EN is defined.
module sa_line_loader import sa_pkg::*; #(
  parameter int DEPTH      = SA_DEPTH,
  parameter int WIDTHS     = SA_WIDTHS,
  parameter int ADDR_WIDTH = SA_ADDR_WIDTH,
  parameter int IN_WIDTH   = SA_IN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTHS-1:0]     wData,
  output logic                  wEn,
  output logic [ADDR_WIDTH-1:0] wAddr,
  output logic                  busy,
  output logic                  done
`ifdef SA_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);
  localparam int WPL = WIDTHS / IN_WIDTH;
  if (WIDTHS % IN_WIDTH != 0 || DEPTH > 2**ADDR_WIDTH) begin : g_bad_cfg
    $error("sa_line_loader: WIDTHS must be a multiple of IN_WIDTH and DEPTH must fit ADDR_WIDTH");
  end
  sa_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, waddr_q, waddr_d;
  logic [WIDTHS-1:0]     wdata_q, wdata_d, line_nxt;
  logic                  wen_q, wen_d, acc, clr, last;
  assign in_ready = state_q == FILL;
  assign busy     = state_q == FILL || state_q == WRITE;
  assign done     = state_q == DONE;
  assign acc      = in_valid && in_ready;
  assign clr      = start && (state_q == IDLE || state_q == DONE);
  assign wEn      = wen_q;
  assign wData    = wdata_q;
  assign wAddr    = waddr_q;
  sa_line_packer #(.IN_WIDTH(IN_WIDTH), .WORDS(WPL)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .acc_i      (acc),
    .word_i     (in_data),
    .last_o     (last),
    .line_nxt_o (line_nxt)
  );
  // Output registers load on the last-word edge so wEn is high exactly during WRITE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wen_d   = 1'b0;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = FILL;
          addr_d  = '0;
        end
      end
      FILL: begin
        if (acc && last) begin
          state_d = WRITE;
          wen_d   = 1'b1;
          wdata_d = line_nxt;
          waddr_d = addr_q;
        end
      end
      default: begin
        state_d = addr_q == ADDR_WIDTH'(DEPTH - 1) ? DONE : FILL;
        addr_d  = addr_q == ADDR_WIDTH'(DEPTH - 1) ? addr_q : addr_q + 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
    end
  end
`ifdef SA_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else if (clr) sum_q <= '0;
    else if (acc) sum_q <= sum_q + 32'(in_data);
  end
  assign checksum = sum_q;
`endif
endmodule

// File: tb/tb_sa_line_loader.sv
// tb_sa_line_loader: scoreboard bench; expected lines are queued at stimulus time and popped on each wEn.
module tb_sa_line_loader;
  localparam int DEPTH = 18;
  localparam int W     = 1920;
  localparam int AW    = 5;
  localparam int IW    = 32;
  localparam int WPL   = W / IW;
  localparam int NW    = DEPTH * WPL;
  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, in_ready, wEn, busy, done;
  logic [IW-1:0] in_data;
  logic [W-1:0]  wData;
  logic [AW-1:0] wAddr;
`ifdef SA_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif
  int            n_checks = 0, n_errors = 0;
  int            cyc = 0, prev_cyc = 0, wen_total = 0, hold_bad = 0;
  bit            gap_chk = 1'b0;
  logic [IW-1:0] words [NW];
  int            exp_addr [$];
  logic [W-1:0]  exp_line [$];
  logic [W-1:0]  last_wd = '0;
  sa_line_loader #(.DEPTH(DEPTH), .WIDTHS(W), .ADDR_WIDTH(AW), .IN_WIDTH(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wData    (wData),
    .wEn      (wEn),
    .wAddr    (wAddr),
    .busy     (busy),
    .done     (done)
`ifdef SA_LOADER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) last_wd = '0;
    else if (wEn) begin
      wen_total++;
      check("wen_in_write", {busy, in_ready}, 2'b10);
      if (exp_addr.size() == 0) check("unexpected_wen", 64'(wAddr) + 1, 0);
      else begin
        int ea;
        logic [W-1:0] el;
        ea = exp_addr.pop_front();
        el = exp_line.pop_front();
        check("waddr", wAddr, ea);
        for (int j = 0; j < WPL; j++) check("wdata_word", wData[j*IW +: IW], el[j*IW +: IW]);
      end
      if (gap_chk && wAddr != 0) check("wen_gap", cyc - prev_cyc, WPL + 1);
      prev_cyc = cyc;
      last_wd  = wData;
    end else if (wData !== last_wd) hold_bad++;
  end
  task automatic push_lines(input int n);
    for (int k = 0; k < n; k++) begin
      logic [W-1:0] l;
      for (int j = 0; j < WPL; j++) l[j*IW +: IW] = words[k*WPL + j];
      exp_addr.push_back(k);
      exp_line.push_back(l);
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic send_words(input int n, input int pct, input int start_at);
    int  i = 0, guard = 0;
    bit  acc, pulsed = 1'b0;
    while (i < n && guard < n * 20) begin
      in_data  = words[i];
      in_valid = $urandom_range(99) < pct;
      start    = (i == start_at) && !pulsed;
      if (start) pulsed = 1'b1;
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("stream_count", i, n);
  endtask
  task automatic finish_load(input int base);
    repeat (3) @(posedge clk);
    #1;
    check("wen_count", wen_total - base, DEPTH);
    check("done_set", {done, busy, in_ready}, 3'b100);
    check("sb_empty", exp_addr.size(), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int base;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #12;
    check("rst_outputs", {wEn, in_ready, busy, done}, 4'b0000);
    check("rst_waddr", wAddr, 0);
    check("rst_wdata", |wData, 0);
`ifdef SA_LOADER_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int j = 0; j < NW; j++) words[j] = j;
    push_lines(DEPTH);
    gap_chk = 1'b1;
    base = wen_total;
    pulse_start();
    check("start_fill", {busy, in_ready, done}, 3'b110);
    send_words(NW, 100, -1);
    finish_load(base);
    gap_chk = 1'b0;
    push_lines(DEPTH);
    base = wen_total;
    pulse_start();
    check("reload_from_done", {busy, in_ready, done}, 3'b110);
    send_words(NW, 50, -1);
    finish_load(base);
    push_lines(3);
    pulse_start();
    send_words(3 * WPL + 31, 70, -1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {wEn, in_ready, busy, done}, 4'b0000);
    check("async_rst_waddr", wAddr, 0);
    check("async_rst_wdata", |wData, 0);
    check("sb_after_rst", exp_addr.size(), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 check("idle_after_rst", {busy, done, wEn}, 3'b000);
    for (int j = 0; j < NW; j++) words[j] = 32'h5000_0000 + j * 7;
    push_lines(DEPTH);
    base = wen_total;
    pulse_start();
    send_words(NW, 80, 100);
    finish_load(base);
`ifdef SA_LOADER_CHECKSUM_EN
    for (int pass = 0; pass < 2; pass++) begin
      logic [31:0] model = '0;
      for (int j = 0; j < NW; j++) begin
        words[j] = pass == 0 ? 32'd1 : 32'hFFFF_FFFF;
        model += words[j];
      end
      push_lines(DEPTH);
      base = wen_total;
      pulse_start();
      check("checksum_cleared", checksum, 0);
      send_words(NW, 100, -1);
      finish_load(base);
      check("checksum", checksum, model);
    end
`endif
    check("wdata_hold", hold_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
